// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: per-L1 request FIFOs feeding one memory port through a round-robin
// arbiter that keeps a single read outstanding and routes each fill back to its requester.
module l2_request_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] snooper_addr_a,
  input  logic [ADDR_W-1:0] snooper_addr_b,
  input  logic [LINE_W-1:0] evictable_cacheline_a,
  input  logic [LINE_W-1:0] evictable_cacheline_b,
  input  logic              eviction_wren_a,
  input  logic              eviction_wren_b,
  input  logic              snooper_read_valid_a,
  input  logic              snooper_read_valid_b,
  output logic [LINE_W-1:0] updated_cacheline_a,
  output logic [LINE_W-1:0] updated_cacheline_b,
  output logic              cacheline_update_valid_a,
  output logic              cacheline_update_valid_b,
  output logic              stall_a,
  output logic              stall_b,
  output logic              overflow_a,
  output logic              overflow_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

  state_t state, state_next;

  // Index 0 is the L1a side, index 1 the L1b side.
  logic [1:0]        req_wr, req_rd, req, push, pop, full, empty;
  logic [ADDR_W-1:0] req_addr [2];
  logic [LINE_W-1:0] req_line [2];

  logic [FIFO_DEPTH-1:0] fifo_wr [2];
  logic [FIFO_DEPTH-1:0] fifo_rd [2];
  logic [ADDR_W-1:0]     fifo_addr [2][FIFO_DEPTH];
  logic [LINE_W-1:0]     fifo_line [2][FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr [2];
  logic [PTR_W-1:0]      rptr [2];
  logic [CNT_W-1:0]      count [2];
  logic [1:0]            overflow_q;

  logic [1:0]        head_wr, head_rd;
  logic [ADDR_W-1:0] head_addr [2];
  logic [LINE_W-1:0] head_line [2];

  logic              rr_b, owner_b, cur_rd;
  logic [ADDR_W-1:0] cur_addr;
  logic              grant_b, load, fill;
  logic              mem_wren_next, mem_rden_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [LINE_W-1:0] mem_wdata_next;

  assign req_wr      = {eviction_wren_b, eviction_wren_a};
  assign req_rd      = {snooper_read_valid_b, snooper_read_valid_a};
  assign req         = req_wr | req_rd;
  assign req_addr[0] = snooper_addr_a;
  assign req_addr[1] = snooper_addr_b;
  assign req_line[0] = evictable_cacheline_a;
  assign req_line[1] = evictable_cacheline_b;

  assign stall_a    = full[0];
  assign stall_b    = full[1];
  assign overflow_a = overflow_q[0];
  assign overflow_b = overflow_q[1];

  // A request arriving while full is dropped even if the arbiter pops that FIFO in the same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p]      = (count[p] == CNT_W'(FIFO_DEPTH));
      empty[p]     = (count[p] == '0);
      push[p]      = req[p] && !full[p];
      head_wr[p]   = fifo_wr[p][rptr[p]];
      head_rd[p]   = fifo_rd[p][rptr[p]];
      head_addr[p] = fifo_addr[p][rptr[p]];
      head_line[p] = fifo_line[p][rptr[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        wptr[p]  <= '0;
        rptr[p]  <= '0;
        count[p] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          fifo_wr[p][wptr[p]]   <= req_wr[p];
          fifo_rd[p][wptr[p]]   <= req_rd[p];
          fifo_addr[p][wptr[p]] <= req_addr[p];
          fifo_line[p][wptr[p]] <= req_line[p];
          wptr[p]               <= wptr[p] + PTR_W'(1);
        end
        if (pop[p]) rptr[p] <= rptr[p] + PTR_W'(1);
        if (push[p] && !pop[p])
          count[p] <= count[p] + CNT_W'(1);
        else if (!push[p] && pop[p])
          count[p] <= count[p] - CNT_W'(1);
        if (req[p] && full[p]) overflow_q[p] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory strobes are computed from the next state so they are registered alongside it.
  always_comb begin
    state_next     = state;
    pop            = 2'b00;
    grant_b        = 1'b0;
    load           = 1'b0;
    fill           = 1'b0;
    mem_wren_next  = 1'b0;
    mem_rden_next  = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    unique case (state)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          grant_b       = !empty[1] && (empty[0] || rr_b);
          pop           = grant_b ? 2'b10 : 2'b01;
          load          = 1'b1;
          mem_addr_next = head_addr[grant_b];
          if (head_wr[grant_b]) begin
            state_next     = WRITE;
            mem_wren_next  = 1'b1;
            mem_wdata_next = head_line[grant_b];
          end else begin
            state_next    = READ;
            mem_rden_next = 1'b1;
          end
        end
      end
      WRITE: begin
        if (cur_rd) begin
          state_next    = READ;
          mem_rden_next = 1'b1;
          mem_addr_next = cur_addr;
        end else begin
          state_next = IDLE;
        end
      end
      READ: state_next = WAIT;
      WAIT: begin
        if (mem_rdata_valid) begin
          state_next = IDLE;
          fill       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_b                     <= 1'b0;
      owner_b                  <= 1'b0;
      cur_rd                   <= 1'b0;
      cur_addr                 <= '0;
      mem_wren                 <= 1'b0;
      mem_rden                 <= 1'b0;
      mem_addr                 <= '0;
      mem_wdata                <= '0;
      updated_cacheline_a      <= '0;
      updated_cacheline_b      <= '0;
      cacheline_update_valid_a <= 1'b0;
      cacheline_update_valid_b <= 1'b0;
    end else begin
      mem_wren  <= mem_wren_next;
      mem_rden  <= mem_rden_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      if (load) begin
        cur_rd   <= head_rd[grant_b];
        cur_addr <= head_addr[grant_b];
        owner_b  <= grant_b;
        rr_b     <= !grant_b;
      end
      cacheline_update_valid_a <= fill && !owner_b;
      cacheline_update_valid_b <= fill && owner_b;
      if (fill && !owner_b) updated_cacheline_a <= mem_rdata;
      if (fill && owner_b)  updated_cacheline_b <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: a timing table, hand-written corner sequences and a
// randomized run scored against per-port request-order queues with a fixed-latency memory.
module tb_l2_request_arbiter;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  snooper_addr_a, snooper_addr_b;
  logic [127:0] evictable_cacheline_a, evictable_cacheline_b;
  logic         eviction_wren_a, eviction_wren_b;
  logic         snooper_read_valid_a, snooper_read_valid_b;
  logic [127:0] updated_cacheline_a, updated_cacheline_b;
  logic         cacheline_update_valid_a, cacheline_update_valid_b;
  logic         stall_a, stall_b, overflow_a, overflow_b;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_wren, mem_rden;
  logic [127:0] mem_rdata = '0;
  logic         mem_rdata_valid = 1'b0;

  l2_request_arbiter #(.FIFO_DEPTH(4), .ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .snooper_addr_a(snooper_addr_a), .snooper_addr_b(snooper_addr_b),
    .evictable_cacheline_a(evictable_cacheline_a), .evictable_cacheline_b(evictable_cacheline_b),
    .eviction_wren_a(eviction_wren_a), .eviction_wren_b(eviction_wren_b),
    .snooper_read_valid_a(snooper_read_valid_a), .snooper_read_valid_b(snooper_read_valid_b),
    .updated_cacheline_a(updated_cacheline_a), .updated_cacheline_b(updated_cacheline_b),
    .cacheline_update_valid_a(cacheline_update_valid_a),
    .cacheline_update_valid_b(cacheline_update_valid_b),
    .stall_a(stall_a), .stall_b(stall_b), .overflow_a(overflow_a), .overflow_b(overflow_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  // kind: 0 = memory write, 1 = memory read, 2 = fill returned to an L1
  typedef struct {int cyc; int kind; int port; logic [31:0] addr; logic [127:0] data;} ev_t;
  typedef struct {int kind; logic [31:0] addr; logic [127:0] line;} op_t;
  typedef struct {
    int port; bit wr; bit rd; logic [31:0] addr; logic [127:0] line;
    int wren_at; int rden_at; int fill_at;
  } vec_t;

  ev_t         ev_q[$];
  op_t         exp_a[$];
  op_t         exp_b[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_pend_addr = '0;
  bit          stray_req = 1'b0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'h1111_1111, ~a, a + 32'h0000_0055, a ^ 32'hCAFE_0000};
  endfunction

  function automatic ev_t mk_ev(input int c, input int k, input int p,
                                input logic [31:0] a, input logic [127:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.port = p; e.addr = a; e.data = d;
    return e;
  endfunction

  // Event logger and fixed-latency memory, sampled 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_rdata_valid = 1'b0;
      if (mem_wren) ev_q.push_back(mk_ev(cyc, 0, 0, mem_addr, mem_wdata));
      if (mem_rden) ev_q.push_back(mk_ev(cyc, 1, 0, mem_addr, 128'h0));
      if (cacheline_update_valid_a) ev_q.push_back(mk_ev(cyc, 2, 0, 32'h0, updated_cacheline_a));
      if (cacheline_update_valid_b) ev_q.push_back(mk_ev(cyc, 2, 1, 32'h0, updated_cacheline_b));
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rdata_valid = 1'b1;
          mem_rdata       = line_of(mem_pend_addr);
        end
      end
      if (mem_rden) begin
        mem_cnt       = LAT;
        mem_pend_addr = mem_addr;
      end
      if (stray_req) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = {4{32'hBAD0_BAD0}};
        stray_req       = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic set_port(input int p, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [127:0] l);
    if (p == 0) begin
      eviction_wren_a = wr; snooper_read_valid_a = rd;
      snooper_addr_a = a;   evictable_cacheline_a = l;
    end else begin
      eviction_wren_b = wr; snooper_read_valid_b = rd;
      snooper_addr_b = a;   evictable_cacheline_b = l;
    end
  endtask

  // Presents whatever set_port staged for one edge; n is the edge that samples it.
  task automatic applyStimulus(output int n);
    n = cyc + 1;
    @(posedge clk);
    #2;
    eviction_wren_a = 1'b0; snooper_read_valid_a = 1'b0;
    eviction_wren_b = 1'b0; snooper_read_valid_b = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_ev(input string name, input int idx, input int kind, input int port,
                           input int c, input logic [31:0] a, input logic [127:0] d);
    ev_t e;
    if (idx >= ev_q.size()) begin
      checkOutput({name, " missing"}, 256'(ev_q.size()), 256'(idx + 1));
    end else begin
      e = ev_q[idx];
      checkOutput(name, 256'({8'(e.kind), 8'(e.port), 32'(e.cyc), e.addr, e.data}),
                  256'({8'(kind), 8'(port), 32'(c), a, d}));
    end
  endtask

  vec_t        vt[6];
  int          n, n2, m, k, nev, nfill, nrd, out_port;
  bit          out_busy;
  logic [31:0] out_addr, a;
  logic [127:0] l, last_fill;
  op_t         o;
  ev_t         e;

  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 128'h0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset mem outputs", 256'({mem_wren, mem_rden, mem_addr, mem_wdata}), 256'(0));
    checkOutput("reset flags",
                256'({cacheline_update_valid_a, cacheline_update_valid_b,
                      stall_a, stall_b, overflow_a, overflow_b}), 256'(0));
    checkOutput("reset fill data", {updated_cacheline_a, updated_cacheline_b}, 256'(0));
    reset = 1'b0;
    idle(1);

    // Single requests into an idle block; offsets are relative to the sampling edge.
    vt[0] = '{0, 1'b0, 1'b1, 32'h0000_0ABC, 128'h0, -1, 1, 2 + LAT};
    vt[1] = '{1, 1'b0, 1'b1, 32'h1234_5670, 128'h0, -1, 1, 2 + LAT};
    vt[2] = '{1, 1'b1, 1'b1, 32'h0000_0040, {4{32'hDEAD_BEEF}}, 1, 2, 3 + LAT};
    vt[3] = '{0, 1'b1, 1'b0, 32'h0000_1000, {4{32'h0123_4567}}, 1, -1, -1};
    vt[4] = '{0, 1'b1, 1'b1, 32'h7FFF_FFC0, {4{32'hA5A5_5A5A}}, 1, 2, 3 + LAT};
    vt[5] = '{1, 1'b1, 1'b0, 32'hFFFF_FF00, {4{32'h0F0F_F0F0}}, 1, -1, -1};
    for (int i = 0; i < 6; i++) begin
      ev_q.delete();
      set_port(vt[i].port, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].line);
      applyStimulus(n);
      idle(14);
      nev = int'(vt[i].wren_at >= 0) + int'(vt[i].rden_at >= 0) + int'(vt[i].fill_at >= 0);
      checkOutput($sformatf("vec%0d event count", i), 256'(ev_q.size()), 256'(nev));
      k = 0;
      if (vt[i].wren_at >= 0) begin
        expect_ev($sformatf("vec%0d write", i), k, 0, 0, n + vt[i].wren_at,
                  vt[i].addr, vt[i].line);
        k++;
      end
      if (vt[i].rden_at >= 0) begin
        expect_ev($sformatf("vec%0d read", i), k, 1, 0, n + vt[i].rden_at, vt[i].addr, 128'h0);
        k++;
      end
      if (vt[i].fill_at >= 0)
        expect_ev($sformatf("vec%0d fill", i), k, 2, vt[i].port, n + vt[i].fill_at,
                  32'h0, line_of(vt[i].addr));
    end

    // Contention: A wins first; a second A read arriving during A's wait loses to pending B.
    ev_q.delete();
    set_port(0, 1'b0, 1'b1, 32'h0000_0A00, 128'h0);
    set_port(1, 1'b0, 1'b1, 32'h8000_0B00, 128'h0);
    applyStimulus(n);
    idle(1);
    set_port(0, 1'b0, 1'b1, 32'h0000_0C00, 128'h0);
    applyStimulus(n2);
    idle(28);
    expect_ev("rr read A1", 0, 1, 0, n + 1, 32'h0000_0A00, 128'h0);
    expect_ev("rr fill A1", 1, 2, 0, n + 2 + LAT, 32'h0, line_of(32'h0000_0A00));
    expect_ev("rr read B", 2, 1, 0, n + 3 + LAT, 32'h8000_0B00, 128'h0);
    expect_ev("rr fill B", 3, 2, 1, n + 4 + 2 * LAT, 32'h0, line_of(32'h8000_0B00));
    expect_ev("rr read A2", 4, 1, 0, n + 5 + 2 * LAT, 32'h0000_0C00, 128'h0);
    expect_ev("rr fill A2", 5, 2, 0, n + 6 + 3 * LAT, 32'h0, line_of(32'h0000_0C00));

    // Overflow: five back-to-back reads on A while its first read waits on memory.
    ev_q.delete();
    set_port(0, 1'b0, 1'b1, 32'h0000_2000, 128'h0);
    applyStimulus(n);
    idle(1);
    for (int j = 1; j <= 5; j++) begin
      set_port(0, 1'b0, 1'b1, 32'h0000_2000 + 32'(j * 'h40), 128'h0);
      applyStimulus(m);
      if (j == 3) checkOutput("stall_a after 3", 256'(stall_a), 256'(0));
      if (j == 4) checkOutput("stall/ovf after 4", 256'({stall_a, overflow_a}), 256'(2'b10));
      if (j == 5) checkOutput("stall/ovf after 5", 256'({stall_a, overflow_a}), 256'(2'b11));
    end
    idle(60);
    nfill = 0; nrd = 0; last_fill = '0;
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == 1) nrd++;
      if (ev_q[i].kind == 2 && ev_q[i].port == 0) begin
        nfill++;
        last_fill = ev_q[i].data;
      end
    end
    checkOutput("overflow reads", 256'(nrd), 256'(5));
    checkOutput("overflow fills A", 256'(nfill), 256'(5));
    checkOutput("overflow last fill", 256'(last_fill), 256'(line_of(32'h0000_2100)));
    checkOutput("overflow sticky", 256'({overflow_a, stall_a, overflow_b, stall_b}), 256'(4'b1000));

    // Reset during WAIT: everything clears and the late memory response is ignored.
    set_port(0, 1'b0, 1'b1, 32'h0000_2800, 128'h0);
    applyStimulus(n);
    idle(3);
    ev_q.delete();
    reset = 1'b1;
    idle(1);
    checkOutput("wait-reset mem outputs", 256'({mem_wren, mem_rden, mem_addr, mem_wdata}), 256'(0));
    checkOutput("wait-reset flags",
                256'({cacheline_update_valid_a, cacheline_update_valid_b,
                      stall_a, stall_b, overflow_a, overflow_b}), 256'(0));
    checkOutput("wait-reset fill data", {updated_cacheline_a, updated_cacheline_b}, 256'(0));
    reset = 1'b0;
    idle(12);
    checkOutput("late valid ignored", 256'(ev_q.size()), 256'(0));
    set_port(0, 1'b0, 1'b1, 32'h0000_3000, 128'h0);
    applyStimulus(n);
    idle(12);
    expect_ev("post-reset read", 0, 1, 0, n + 1, 32'h0000_3000, 128'h0);
    expect_ev("post-reset fill", 1, 2, 0, n + 2 + LAT, 32'h0, line_of(32'h0000_3000));

    // Stray read data while idle produces nothing and leaves the held fill line alone.
    ev_q.delete();
    stray_req = 1'b1;
    idle(6);
    checkOutput("stray no events", 256'(ev_q.size()), 256'(0));
    checkOutput("stray holds line A", 256'(updated_cacheline_a), 256'(line_of(32'h0000_3000)));
    set_port(1, 1'b0, 1'b1, 32'h8000_4000, 128'h0);
    applyStimulus(n);
    idle(12);
    expect_ev("post-stray read", 0, 1, 0, n + 1, 32'h8000_4000, 128'h0);
    expect_ev("post-stray fill", 1, 2, 1, n + 2 + LAT, 32'h0, line_of(32'h8000_4000));

    // Randomized traffic that respects stall; A addresses have bit 31 clear, B set.
    ev_q.delete();
    nev = 0;
    for (int c = 0; c < 200; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? !stall_a : !stall_b) && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(1, 3);
          a = $urandom & 32'h7FFF_FFF0;
          if (p == 1) a = a | 32'h8000_0000;
          l = {$urandom, $urandom, $urandom, $urandom};
          set_port(p, k[0], k[1], a, l);
          if (k[0]) begin
            o.kind = 0; o.addr = a; o.line = l;
            if (p == 0) exp_a.push_back(o); else exp_b.push_back(o);
            nev = nev + 1;
          end
          if (k[1]) begin
            o.kind = 1; o.addr = a; o.line = 128'h0;
            if (p == 0) exp_a.push_back(o); else exp_b.push_back(o);
            nev = nev + 2;
          end
        end
      end
      applyStimulus(n);
    end
    for (int w = 0; w < 2000 && ev_q.size() < nev; w++) idle(1);
    idle(3);
    checkOutput("random event count", 256'(ev_q.size()), 256'(nev));
    out_busy = 1'b0; out_port = 0; out_addr = '0;
    foreach (ev_q[i]) begin
      e = ev_q[i];
      if (e.kind == 2) begin
        checkOutput($sformatf("rnd fill %0d", i), 256'({8'(out_busy), 8'(e.port), e.data}),
                    256'({8'd1, 8'(out_port), line_of(out_addr)}));
        out_busy = 1'b0;
      end else begin
        o.kind = 9; o.addr = '0; o.line = '0;
        if (e.addr[31] == 1'b0 && exp_a.size() > 0) o = exp_a.pop_front();
        else if (e.addr[31] == 1'b1 && exp_b.size() > 0) o = exp_b.pop_front();
        checkOutput($sformatf("rnd op %0d", i), 256'({8'(e.kind), e.addr, e.data}),
                    256'({8'(o.kind), o.addr, o.line}));
        if (e.kind == 1) begin
          checkOutput($sformatf("rnd single read %0d", i), 256'(out_busy), 256'(0));
          out_busy = 1'b1;
          out_port = int'(e.addr[31]);
          out_addr = e.addr;
        end
      end
    end
    checkOutput("rnd leftover", 256'(exp_a.size() + exp_b.size() + int'(out_busy)), 256'(0));
    checkOutput("rnd no overflow", 256'({overflow_a, overflow_b}), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
